// File: rtl/background_scanner.sv
// Frame-sweep sequencer: walks WIDTH x HEIGHT in raster order, feeds `background`, and plots its colours.
// Optional `SCANNER_SKIP_BLACK_EN`: suppress plot for pixels whose colour is 3'b000.
module background_scanner #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic [2:0] flag_in,
    output logic [8:0] x_cord,
    output logic [8:0] y_cord,
    output logic [8:0] x_out,
    output logic [8:0] y_out,
    output logic [2:0] colour_out,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    // Handshakes: `start` is a request sampled only in IDLE (no ready, never queued);
    // `plot` is a write strobe with no backpressure, each high cycle carries one pixel.
    localparam logic [8:0] X_LAST = 9'(WIDTH - 1);
    localparam logic [8:0] Y_LAST = 9'(HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t     state;
    logic [8:0] x_cnt;
    logic [8:0] y_cnt;
    logic       cord_valid;
    logic [8:0] s1_x;
    logic [8:0] s1_y;
    logic       s1_valid;
    logic       drain_cnt;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            x_cnt      <= '0;
            y_cnt      <= '0;
            x_cord     <= '0;
            y_cord     <= '0;
            cord_valid <= 1'b0;
            s1_x       <= '0;
            s1_y       <= '0;
            s1_valid   <= 1'b0;
            drain_cnt  <= 1'b0;
            x_out      <= '0;
            y_out      <= '0;
            colour_out <= '0;
            plot       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            cord_valid <= 1'b0;
            done       <= 1'b0;
            busy       <= (state == SCAN) || (state == DRAIN);

            case (state)
                IDLE: begin
                    x_cnt <= '0;
                    y_cnt <= '0;
                    if (start) state <= SCAN;
                end
                SCAN: begin
                    x_cord     <= x_cnt;
                    y_cord     <= y_cnt;
                    cord_valid <= 1'b1;
                    if (x_cnt == X_LAST) begin
                        // Last pixel: counters freeze until DONE clears them.
                        if (y_cnt == Y_LAST) begin
                            state     <= DRAIN;
                            drain_cnt <= 1'b0;
                        end else begin
                            x_cnt <= '0;
                            y_cnt <= y_cnt + 9'd1;
                        end
                    end else begin
                        x_cnt <= x_cnt + 9'd1;
                    end
                end
                DRAIN: begin
                    drain_cnt <= 1'b1;
                    if (drain_cnt) state <= DONE;
                end
                DONE: begin
                    done  <= 1'b1;
                    x_cnt <= '0;
                    y_cnt <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Stage 1 lines the coordinate up with the registered colour from `background`.
            s1_x     <= x_cord;
            s1_y     <= y_cord;
            s1_valid <= cord_valid;

            x_out      <= s1_x;
            y_out      <= s1_y;
            colour_out <= flag_in;
`ifdef SCANNER_SKIP_BLACK_EN
            plot       <= s1_valid && (flag_in != 3'b000);
`else
            plot       <= s1_valid;
`endif
        end
    end

endmodule

// File: tb/tb_background_scanner.sv
// Directed bench for background_scanner on a 4x3 frame: per-cycle model compare plus write scoreboard.
// Honours SCANNER_SKIP_BLACK_EN when the design is built with it.
module tb_background_scanner;
    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;
`ifdef SCANNER_SKIP_BLACK_EN
    localparam int NPLOT = 6;
`else
    localparam int NPLOT = 12;
`endif

    logic       clock = 1'b0;
    logic       resetn;
    logic       start;
    logic [2:0] flag_in;
    logic [8:0] x_cord, y_cord, x_out, y_out;
    logic [2:0] colour_out;
    logic       plot, busy, done;

    int checks = 0;
    int failures = 0;
    int rel = -1;
    int done_count = 0;
    int done_rel = -1;
    int frame_plots = 0;
    bit log_en = 1'b0;
    logic [20:0] exp_q[$];
    logic [20:0] got_q[$];

    background_scanner #(.WIDTH(W), .HEIGHT(H)) dut (
        .clock(clock), .resetn(resetn), .start(start), .flag_in(flag_in),
        .x_cord(x_cord), .y_cord(y_cord), .x_out(x_out), .y_out(y_out),
        .colour_out(colour_out), .plot(plot), .busy(busy), .done(done)
    );

    // ---- clock / reset ----
    always #5 clock = ~clock;

    // ---- helpers ----
    function automatic logic [2:0] bg(input int x, input int y);
        return (x % 2 == 1) ? 3'((2 * y + x) % 8) : 3'd0;
    endfunction

    function automatic logic [20:0] wr(input int x, input int y, input int c);
        return {9'(x), 9'(y), 3'(c)};
    endfunction

    function automatic bit plotted(input int x, input int y);
`ifdef SCANNER_SKIP_BLACK_EN
        return bg(x, y) != 3'd0;
`else
        return 1'b1;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Registered colour lookup standing in for `background`.
    always @(posedge clock or negedge resetn) begin
        if (!resetn) flag_in <= 3'd0;
        else flag_in <= bg(int'(x_cord), int'(y_cord));
    end

    // ---- model: frame timeline relative to the edge that accepted start ----
    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rel = -1;
            exp_q.delete();
        end else if (rel >= 0 && rel < N + 3) begin
            rel = rel + 1;
        end else if (start) begin
            rel = 0;
            for (int p = 0; p < N; p++)
                if (plotted(p % W, p / W)) exp_q.push_back(wr(p % W, p / W, int'(bg(p % W, p / W))));
        end else begin
            rel = -1;
        end
    end

    // ---- compare process ----
    always @(negedge clock) begin
        bit in_plot;
        int pidx;
        logic [20:0] got, e;
        in_plot = (rel >= 3 && rel <= N + 2);
        pidx = rel - 3;
        chk("plot", plot, in_plot && plotted(pidx % W, pidx / W));
        chk("busy", busy, rel >= 1 && rel <= N + 2);
        chk("done", done, rel == N + 3);
        if (in_plot) begin
            chk("x_out", x_out, pidx % W);
            chk("y_out", y_out, pidx / W);
            chk("colour_out", colour_out, bg(pidx % W, pidx / W));
        end
        if (rel >= 1 && rel <= N) begin
            chk("x_cord", x_cord, (rel - 1) % W);
            chk("y_cord", y_cord, (rel - 1) / W);
        end
        if (plot) begin
            got = {x_out, y_out, colour_out};
            frame_plots++;
            if (log_en) got_q.push_back(got);
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_write actual=%0h expected=none at %0t", got, $time);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    failures++;
                    $display("FAIL sb_write actual=%0h expected=%0h at %0t", got, e, $time);
                end
            end
        end
        if (done) begin
            done_count++;
            done_rel = rel;
            chk("sb_drained", exp_q.size(), 0);
            chk("frame_plots", frame_plots, NPLOT);
            frame_plots = 0;
        end
        if (!resetn) frame_plots = 0;
    end

    // ---- driver tasks ----
    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max);
        bit seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge clock);
            #1;
            if (done) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL done_timeout actual=no_done expected=done within %0d cycles", max);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_x_cord"}, x_cord, 0);
        chk({tag, "_y_cord"}, y_cord, 0);
        chk({tag, "_x_out"}, x_out, 0);
        chk({tag, "_y_out"}, y_out, 0);
        chk({tag, "_colour"}, colour_out, 0);
        chk({tag, "_plot"}, plot, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    // ---- directed sequence ----
    initial begin
        int d0;
        resetn = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        #1 check_zero_outputs("reset");
        resetn = 1'b1;

        // Frame 1: single start, log every write.
        log_en = 1'b1;
        pulse_start();
        wait_done(40);
        repeat (3) @(negedge clock);
        log_en = 1'b0;
        chk("f1_write_count", got_q.size(), NPLOT);
        chk("f1_done_rel", done_rel, 15);
        chk("f1_done_count", done_count, 1);
        if (got_q.size() == NPLOT) begin
`ifdef SCANNER_SKIP_BLACK_EN
            chk("f1_first", got_q[0], wr(1, 0, 1));
            chk("f1_mid", got_q[2], wr(1, 1, 3));
            chk("f1_last", got_q[5], wr(3, 2, 7));
`else
            chk("f1_first", got_q[0], wr(0, 0, 0));
            chk("f1_row_end", got_q[3], wr(3, 0, 3));
            chk("f1_row_wrap", got_q[4], wr(0, 1, 0));
            chk("f1_mid", got_q[5], wr(1, 1, 3));
            chk("f1_last", got_q[11], wr(3, 2, 7));
`endif
        end

        // Frame 2: start re-pulsed mid-scan must be ignored.
        pulse_start();
        repeat (6) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done(40);
        repeat (8) @(negedge clock);
        chk("f2_done_count", done_count, 2);

        // Frame 3: asynchronous reset mid-frame, then a clean frame.
        pulse_start();
        repeat (5) @(negedge clock);
        #2 resetn = 1'b0;
        #1 check_zero_outputs("midreset");
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        repeat (6) @(negedge clock);
        chk("post_reset_done_count", done_count, 2);
        pulse_start();
        wait_done(40);
        repeat (3) @(negedge clock);
        chk("f3_done_count", done_count, 3);

        // Frames 4-6: start held high gives back-to-back frames.
        d0 = done_count;
        @(negedge clock);
        start = 1'b1;
        repeat (3 * (N + 4)) @(negedge clock);
        start = 1'b0;
        repeat (N + 10) @(negedge clock);
        chk("held_done_count", done_count - d0, 3);
        chk("final_sb_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
